spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
SPI responder (mode 0, write-only) that turns host frames into the five control registers read by pwm_peripheral.
- Inputs are the raw SPI pins from the top level: ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS.
- All pins are asynchronous to clk. They are synchronised, then edge-detected in the clk domain.
- The register outputs connect directly to pwm_peripheral's en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.

Parameters:
SYNC_STAGES, 2, number of flops in each pin synchroniser (minimum 2).
MAX_ADDR, 4, highest writable register address. Higher addresses are discarded.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from host (async)
copi  input  1  SPI data, host to peripheral (async)
ncs  input  1  SPI chip select, active low (async)
en_reg_out_7_0  output  8  register 0x00
en_reg_out_15_8  output  8  register 0x01
en_reg_pwm_7_0  output  8  register 0x02
en_reg_pwm_15_8  output  8  register 0x03
pwm_duty_cycle  output  8  register 0x04

Behaviour:
- Reset: rst_n low asynchronously clears all five registers, the synchronisers, the shift register and the bit counter, and sets state=IDLE.
- Synchronisers: each pin passes through SYNC_STAGES flops, plus one history flop.
  - Rise is detected when sync=1 and history=0; fall when sync=0 and history=1.
  - copi is sampled from its synchronised value in the same cycle the SCLK rise is detected.
- Frame format, 16 bits, MSB first:
  - bit15: R/W, 1=write.
  - bits14:8: 7-bit address.
  - bits7:0: data.
- State IDLE:
  - SCLK edges are ignored.
  - An nCS fall clears the shift register and count, then moves to ACTIVE.
- State ACTIVE:
  - Each SCLK rise shifts copi into the LSB and increments count.
  - count is 5 bits and saturates at 31.
  - SCLK falls are ignored.
- nCS rise in ACTIVE commits the frame and returns to IDLE. The frame is committed only if all of these hold:
  - count==16,
  - bit15==1,
  - addr<=MAX_ADDR.
  - Otherwise the frame is discarded and no register changes.
- Commit timing: the register output updates on the clk edge after the cycle in which the nCS rise is detected.
  - With SYNC_STAGES=2, this is the 3rd clk rising edge after nCS goes high at the pin.
- Register mapping: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
  - Only the addressed register changes; the others hold.
- Simultaneous events: if an SCLK rise and an nCS rise are detected in the same cycle, nCS wins. That SCLK edge is not shifted.
- Glitch or abort handling:
  - An nCS rise with fewer than 16 bits is discarded.
  - More than 16 bits is discarded; saturation prevents wrap back to 16.
- An nCS fall while already in ACTIVE cannot occur without an intervening rise, so no special handling is required.
- Reset mid-frame: the partial frame is lost and state is IDLE.
  - If nCS is still low when rst_n releases, remaining SCLK edges are ignored until the next nCS fall.
- Read frames (bit15==0) are accepted on the wire and have no effect. There is no CIPO output.
- Timing requirement on the host: SCLK high and low time ≥ (SYNC_STAGES+1) clk periods each; nCS setup/hold to SCLK ≥ same.

Test Plan:
- Reset: assert rst_n=0 mid-run → all five outputs read 0x00 immediately, without waiting for a clk edge.
- Basic write: frame 0x80F0 → en_reg_out_7_0=0xF0 on the 3rd clk edge after nCS rises, not earlier. Then frame 0x8480 → pwm_duty_cycle=0x80 and en_reg_out_7_0 still 0xF0.
- All addresses: frames 0x8011, 0x8122, 0x8233, 0x8344, 0x8455 → registers 0x00..0x04 read 0x11, 0x22, 0x33, 0x44, 0x55.
- Rejects, each → no register changes:
  - read frame 0x00AA,
  - invalid address 0x85AA,
  - 15-bit frame,
  - 17-bit frame,
  - 32 SCLKs in one frame (saturation check).
- Reset mid-frame: send 8 bits of 0x80FF, pulse rst_n, send the remaining 8 bits, raise nCS → all registers 0x00. The next full frame 0x80FF → en_reg_out_7_0=0xFF.
- Collision: place the 16th SCLK rise in the same synchronised cycle as the nCS rise → count=15, frame discarded, registers unchanged.

Source files
------------

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - write-only mode-0 SPI responder feeding five 8-bit control registers
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    localparam logic [6:0] LP_MAX_ADDR = 7'(MAX_ADDR);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_hist;
    logic                   r_ncs_hist;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_shift;
    logic [4:0]  r_count;

    logic [7:0]  r_out_lo;
    logic [7:0]  r_out_hi;
    logic [7:0]  r_pwm_lo;
    logic [7:0]  r_pwm_hi;
    logic [7:0]  r_duty;

    logic        w_sclk_s;
    logic        w_copi_s;
    logic        w_ncs_s;
    logic        w_sclk_rise;
    logic        w_ncs_rise;
    logic        w_ncs_fall;
    logic        w_clear;
    logic        w_shift;
    logic        w_end_frame;
    logic        w_commit;

    // Bring the three pins into the clk domain; history flops give one-cycle edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
            r_sclk_hist <= 1'b0;
            r_ncs_hist  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_ncs_hist  <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_hist;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_hist;

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; an nCS rise takes priority over a coincident SCLK rise
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_end_frame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_ncs_rise) begin
                    w_end_frame = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift register and saturating bit counter; saturation keeps long frames from aliasing to 16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_shift) begin
            r_shift <= {r_shift[14:0], w_copi_s};
            if (r_count != 5'd31) begin
                r_count <= r_count + 5'd1;
            end
        end
    end

    assign w_commit = w_end_frame && (r_count == 5'd16) && r_shift[15]
                      && (r_shift[14:8] <= LP_MAX_ADDR);

    // Write only the addressed register on a well-formed write frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_lo <= '0;
            r_out_hi <= '0;
            r_pwm_lo <= '0;
            r_pwm_hi <= '0;
            r_duty   <= '0;
        end else if (w_commit) begin
            case (r_shift[14:8])
                7'd0:    r_out_lo <= r_shift[7:0];
                7'd1:    r_out_hi <= r_shift[7:0];
                7'd2:    r_pwm_lo <= r_shift[7:0];
                7'd3:    r_pwm_hi <= r_shift[7:0];
                7'd4:    r_duty   <= r_shift[7:0];
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = r_out_lo;
    assign en_reg_out_15_8 = r_out_hi;
    assign en_reg_pwm_7_0  = r_pwm_lo;
    assign en_reg_pwm_15_8 = r_pwm_hi;
    assign pwm_duty_cycle  = r_duty;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - scoreboard testbench for spi_peripheral
module tb_spi_peripheral;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    spi_peripheral #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle)
    );

    typedef struct {
        int          due;
        logic [39:0] regs;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [39:0] exp_now;
    logic [39:0] w_regs;

    assign w_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                     en_reg_out_15_8, en_reg_out_7_0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare register snapshot whenever a scheduled expectation comes due
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.due < cyc) begin
                bad++;
                $display("FAIL %s: check slot missed at cycle %0d (due %0d)", e.name, cyc, e.due);
            end else if (w_regs !== e.regs) begin
                bad++;
                $display("FAIL %s: regs got %h expected %h", e.name, w_regs, e.regs);
            end
        end
    end

    function automatic logic [39:0] model(input logic [39:0] cur, input logic [15:0] fr,
                                          input int nbits);
        logic [39:0] r;
        r = cur;
        if (nbits == 16 && fr[15] && fr[14:8] <= 7'd4) begin
            r[fr[10:8]*8 +: 8] = fr[7:0];
        end
        return r;
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [63:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = d[i];
            clk_wait(4);
            sclk = 1'b1;
            clk_wait(4);
            sclk = 1'b0;
        end
    endtask

    task automatic push_pair(input string nm, input int n, input logic [39:0] newv);
        sb.push_back('{due: n + 2, regs: exp_now, name: {nm, "_early"}});
        sb.push_back('{due: n + 3, regs: newv, name: nm});
        exp_now = newv;
    endtask

    task automatic raise_ncs(input string nm, input logic [39:0] newv);
        clk_wait(4);
        ncs = 1'b1;
        push_pair(nm, cyc, newv);
        clk_wait(8);
    endtask

    task automatic do_frame(input string nm, input logic [63:0] d, input int n);
        ncs = 1'b0;
        clk_wait(4);
        shift_bits(d, n);
        raise_ncs(nm, model(exp_now, d[15:0], n));
    endtask

    initial begin
        rst_n   = 1'b0;
        sclk    = 1'b0;
        copi    = 1'b0;
        ncs     = 1'b1;
        exp_now = '0;
        clk_wait(3);
        rst_n = 1'b1;
        sb.push_back('{due: cyc + 1, regs: 40'h0, name: "reset"});
        clk_wait(4);

        do_frame("basic_f0", 64'h80F0, 16);
        do_frame("basic_duty", 64'h8480, 16);
        do_frame("addr0", 64'h8011, 16);
        do_frame("addr1", 64'h8122, 16);
        do_frame("addr2", 64'h8233, 16);
        do_frame("addr3", 64'h8344, 16);
        do_frame("addr4", 64'h8455, 16);

        do_frame("rej_read", 64'h00AA, 16);
        do_frame("rej_addr", 64'h85AA, 16);
        do_frame("rej_15b", 64'h00CC, 15);
        do_frame("rej_17b", 64'h18066, 17);
        do_frame("rej_32b", 64'h80AA80AA, 32);
        do_frame("rej_48b", 64'h80AA80AA8077, 48);

        // 16th SCLK rise and nCS rise land in the same synchronised cycle
        ncs = 1'b0;
        clk_wait(4);
        shift_bits(64'h8099 >> 1, 15);
        copi = 1'b1;
        clk_wait(4);
        sclk = 1'b1;
        ncs  = 1'b1;
        push_pair("collision", cyc, model(exp_now, 16'h8099, 15));
        clk_wait(4);
        sclk = 1'b0;
        clk_wait(8);

        // Reset in the middle of a frame, nCS held low across it
        ncs = 1'b0;
        clk_wait(4);
        shift_bits(64'h80, 8);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (w_regs !== 40'h0) begin
            bad++;
            $display("FAIL async_reset: regs got %h expected %h", w_regs, 40'h0);
        end
        exp_now = '0;
        clk_wait(2);
        rst_n = 1'b1;
        clk_wait(4);
        shift_bits(64'hFF, 8);
        raise_ncs("rst_mid", 40'h0);
        do_frame("after_rst", 64'h80FF, 16);

        for (int k = 0; k < 200 && sb.size() > 0; k++) clk_wait(1);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending entries got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
